fibo_index: RTL
===============

Name: fibo_index

Overview:
- Inverse companion to the team's Fibonacci generator. That generator uses the sequence f(0)=1, f(1)=1, f(n)=f(n-1)+f(n-2).
- Given an 8-bit value v, this block iteratively finds the largest index n with f(n) <= v.
- It reports n, whether v is exactly f(n), and the remainder v - f(n).
- It uses the same start/finished handshake as the generator, so the two can be chained for round-trip checks.

Parameters:
- W, 8, width of value and remainder. Internal sequence registers are W+1 bits wide.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new search. Honoured only in IDLE or DONE.
- value  in  W  operand v. Sampled only on the edge that accepts start.
- index  out  8  largest n with f(n) <= v.
- remainder  out  W  v - f(index).
- exact  out  1  1 when remainder == 0 and v != 0.
- invalid  out  1  1 when the accepted v was 0.
- busy  out  1  1 while in SEARCH.
- finished  out  1  1 while in DONE, i.e. results are valid.

Behaviour:
- Reset: this is the only reset mechanism; there is no asynchronous path.
  - On a rising edge with reset=1: state=IDLE; index, remainder, exact, invalid, busy and finished all become 0.
  - Internal registers are cleared: t1=1, t2=1, k=0, v_reg=0.
  - Reset has priority over start and over any in-progress search. Reset mid-SEARCH aborts without producing results.
- States: IDLE, SEARCH, DONE, encoded in 2 bits. The unused encoding recovers to IDLE on the next edge.
- Accept (IDLE or DONE, start=1):
  - v_reg <= value, t1 <= 1, t2 <= 1, k <= 0.
  - finished <= 0, busy <= 1, state <= SEARCH.
  - Result outputs keep their previous values until the new search completes.
- IDLE/DONE with start=0: hold everything. DONE keeps finished=1 indefinitely.
- SEARCH, one step per cycle. Invariant: t1=f(k), t2=f(k+1).
  - If t2 > v_reg (W+1-bit unsigned compare, v_reg zero-extended):
    - index <= k, remainder <= v_reg - t1, exact <= (v_reg == t1).
    - invalid <= 0, busy <= 0, finished <= 1, state <= DONE.
  - Else: t1 <= t2, t2 <= t1 + t2 (W+1-bit add, cannot overflow), k <= k + 1.
- Width rule: while stepping, t2 <= v_reg < 2^W, so the next t2 < 2^(W+1). t1 never exceeds 2^W-1.
- v=0 special case:
  - The first SEARCH cycle sees t2=1 > 0 and completes.
  - Outputs forced to index=0, remainder=0, exact=0, invalid=1.
- v=1: f(0)=f(1)=1, so the largest index is 1, with exact=1 and remainder=0.
- Latency: let E0 be the edge that accepts start. finished rises on edge E0+index+1, so the block spends index+1 cycles in SEARCH. Worst case for W=8 is v>=233: index=12, 13 cycles.
- start=1 during SEARCH is ignored. value changes during SEARCH have no effect.
- Back-to-back: start held high in DONE restarts on every DONE edge. finished pulses high for exactly one cycle per result.

Test Plan:
- Reset, then v=233, start for 1 cycle -> busy for 13 cycles; finished rises at E0+13; index=12, remainder=0, exact=1, invalid=0.
- v=100 -> finished at E0+11; index=10 (f=89), remainder=11, exact=0.
- v=255 -> index=12, remainder=22, exact=0. Internal t2 reaches 377 with no wraparound.
- v=1 -> index=1, remainder=0, exact=1. Then v=0 -> index=0, remainder=0, exact=0, invalid=1, finished at E0+1.
- Start with v=200, pulse start again at cycle 3 with value=5 (ignored), assert reset at cycle 6 -> all outputs 0, state IDLE. A following start with v=8 -> index=5, exact=1.
- Round trip: for every v in 1..255, feed the result index to the generator -> generator output == v - remainder. Also check exact == (remainder == 0).

Source files
------------

// File: rtl/fibo_index.sv
// rtl/fibo_index.sv - inverse Fibonacci search: largest n with f(n) <= v
// Walks the f(0)=f(1)=1 sequence one term per cycle until the next term overshoots v.
module fibo_index #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] value,
  output logic [7:0]   index,
  output logic [W-1:0] remainder,
  output logic         exact,
  output logic         invalid,
  output logic         busy,
  output logic         finished
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [W:0]   t1;
  logic [W:0]   t2;
  logic [7:0]   k;
  logic [W-1:0] v_reg;
  logic         accept;
  logic         hit;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    hit        = (t2 > {1'b0, v_reg});
    busy       = 1'b0;
    finished   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SEARCH;
        end
      end
      SEARCH: begin
        busy = 1'b1;
        if (hit) state_next = DONE;
      end
      DONE: begin
        finished = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = SEARCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // t1/t2 hold f(k)/f(k+1); results only move when the search terminates
  always_ff @(posedge clk) begin
    if (reset) begin
      t1        <= '0 + 1'b1;
      t2        <= '0 + 1'b1;
      k         <= '0;
      v_reg     <= '0;
      index     <= '0;
      remainder <= '0;
      exact     <= 1'b0;
      invalid   <= 1'b0;
    end else if (accept) begin
      v_reg <= value;
      t1    <= '0 + 1'b1;
      t2    <= '0 + 1'b1;
      k     <= '0;
    end else if (state == SEARCH) begin
      if (hit) begin
        if (v_reg == '0) begin
          index     <= '0;
          remainder <= '0;
          exact     <= 1'b0;
          invalid   <= 1'b1;
        end else begin
          index     <= k;
          remainder <= v_reg - t1[W-1:0];
          exact     <= ({1'b0, v_reg} == t1);
          invalid   <= 1'b0;
        end
      end else begin
        t1 <= t2;
        t2 <= t1 + t2;
        k  <= k + 8'd1;
      end
    end
  end

endmodule
